pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the 9-bit CPU family, replacing the fixed 10-bit counter and single link register. Computes the next fetch address each cycle from a decoded sequencing op: increment, hold, PC-relative conditional branch, absolute conditional jump, page jump, call, and return. Calls and returns use a hardware return-address stack of configurable depth. Sits between the control decoder and instruction memory; `pc` drives the instruction-memory address directly.

## Interface
- `ADDR_W`, 10, program address width
- `OFFSET_W`, 8, width of `offset`; must be < `ADDR_W`; page width is `PAGE_W = ADDR_W - OFFSET_W`
- `STACK_DEPTH`, 4, return-stack entries, ≥ 1
- `RESET_ADDR`, 0, `pc` value while `start_n` is low

Ports:
- `clk`  in  1  clock, rising edge
- `start_n`  in  1  reset, asynchronous assert, active-low
- `restart`  in  1  synchronous restart: load `start_address`, clear stack
- `start_address`  in  ADDR_W  restart target
- `op`  in  3  sequencing op, see Operation
- `cond`  in  1  branch/jump condition, evaluated by the caller
- `offset`  in  OFFSET_W  relative displacement (signed) or in-page offset (unsigned)
- `page`  in  PAGE_W  page select for PAGE
- `target`  in  ADDR_W  absolute target for JMP/CALL
- `pc`  out  ADDR_W  current fetch address, registered
- `depth`  out  $clog2(STACK_DEPTH+1)  occupied stack entries
- `stk_full`  out  1  `depth == STACK_DEPTH`
- `stk_empty`  out  1  `depth == 0`
- `err`  out  1  sticky stack fault (always 0 when `PCSEQ_STACK_GUARD_EN` is undefined)

## Operation
- Reset (`start_n` low): `pc = RESET_ADDR`, `depth = 0`, `stk_empty = 1`, `stk_full = 0`, `err = 0`; stack contents don't-care.
- Priority per cycle: `restart` > `err` halt > `op`.
- `restart`: `pc <= start_address`, `depth <= 0`, `err <= 0`; `op` ignored.
- `op` encoding, with `npc = pc + 1`:
  - 0 NEXT: `pc <= npc`.
  - 1 HOLD: `pc` unchanged.
  - 2 BR: `cond` ? `pc + sext(offset)` : `npc`.
  - 3 JMP: `cond` ? `target` : `npc`.
  - 4 PAGE: `pc <= {page, offset}`, unconditional.
  - 5 CALL: push `npc`, `pc <= target`.
  - 6 RET: pop, `pc <=` popped value.
  - 7 reserved: behaves as NEXT.
- All address arithmetic is modulo 2^ADDR_W: `pc` all-ones + NEXT → 0; BR wraps in both directions.
- The stack is LIFO. Push writes entry `depth` then increments it; pop reads entry `depth-1` then decrements it.
- Boundary behaviour without the guard:
  - CALL when full: the oldest entry is discarded (circular overwrite), the call proceeds, `depth` stays `STACK_DEPTH`.
  - RET when empty: `pc <= npc`, `depth` stays 0.

## Timing
- Single-cycle latency: op, inputs, and `cond` sampled at edge N; new `pc`, `depth`, and flags are valid after edge N.
- `stk_full` and `stk_empty` are registered, consistent with `depth` in the same cycle.
- `start_n` deassertion is synchronised internally, so the first op is accepted on the second rising edge after release.
- Assertion of `start_n` mid-operation forces reset values immediately, with no clock required.

## Configuration
- `PCSEQ_STACK_GUARD_EN` defined:
  - CALL when full or RET when empty sets `err`.
  - The offending op has no effect on `pc` or the stack.
  - While `err = 1`, `pc` holds and all ops are ignored until `restart` or reset.
- `PCSEQ_STACK_GUARD_EN` undefined: wrap/overwrite behaviour described under Operation; `err` tied 0.

## Test plan
- Reset and increment: `start_n` low → `pc = RESET_ADDR` (0). Release, then 3× NEXT → `pc` steps 1, 2, 3. At `pc = 0x3FF`, NEXT → 0x000.
- Branch: `pc = 0x010`, BR `offset = 0xFE`, `cond = 1` → 0x00E. Same with `cond = 0` → 0x011. `pc = 0x001`, BR `offset = 0xFC`, `cond = 1` → 0x3FD.
- Page and jump: PAGE `page = 2'b10`, `offset = 0x34` → 0x234. JMP `target = 0x155`, `cond = 1` → 0x155.
- Nested calls: CALL 0x100 from 0x020, then CALL 0x200 from 0x100, then 2× RET → `pc` 0x101 then 0x021, `depth` 2→1→0, `stk_empty = 1` at the end.
- Overflow: 5× CALL with `STACK_DEPTH = 4`:
  - Guard defined: the fifth CALL sets `err`, `pc` frozen at its pre-call value, further ops ignored; `restart` with `start_address = 0x040` → `pc = 0x040`, `err = 0`, `depth = 0`.
  - Guard undefined: 4× RET returns the four newest return addresses, and a fifth RET yields `npc`.
- Priority and async reset: `restart` together with CALL → `pc = start_address`, `depth = 0`. Pulse `start_n` low mid-CALL sequence → immediate `pc = 0`, `depth = 0`.

Source files
------------

// File: rtl/pc_seq_if.sv
// Sequencing bus between the control decoder (master) and pc_sequencer (slave).
interface pc_seq_if #(
   parameter int ADDR_W      = 10,
   parameter int OFFSET_W    = 8,
   parameter int STACK_DEPTH = 4
);
   localparam int PAGE_W  = ADDR_W - OFFSET_W;
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   logic                restart;
   logic [ADDR_W-1:0]   start_address;
   logic [2:0]          op;
   logic                cond;
   logic [OFFSET_W-1:0] offset;
   logic [PAGE_W-1:0]   page;
   logic [ADDR_W-1:0]   target;
   logic [ADDR_W-1:0]   pc;
   logic [DEPTH_W-1:0]  depth;
   logic                stk_full;
   logic                stk_empty;
   logic                err;

   modport master (
      output restart, start_address, op, cond, offset, page, target,
      input  pc, depth, stk_full, stk_empty, err
   );

   modport slave (
      input  restart, start_address, op, cond, offset, page, target,
      output pc, depth, stk_full, stk_empty, err
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular hardware return-address stack.
// Define PCSEQ_STACK_GUARD_EN to halt with a sticky err on stack overflow/underflow.
module pc_sequencer #(
   parameter int ADDR_W      = 10,
   parameter int OFFSET_W    = 8,
   parameter int STACK_DEPTH = 4,
   parameter int RESET_ADDR  = 0
) (
   input logic     clk,
   input logic     start_n,
   pc_seq_if.slave bus
);
   localparam int PAGE_W  = ADDR_W - OFFSET_W;
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_HOLD = 3'd1;
   localparam logic [2:0] OP_BR   = 3'd2;
   localparam logic [2:0] OP_JMP  = 3'd3;
   localparam logic [2:0] OP_PAGE = 3'd4;
   localparam logic [2:0] OP_CALL = 3'd5;
   localparam logic [2:0] OP_RET  = 3'd6;

   // ST_SYNC absorbs the first edge after start_n release
   typedef enum logic [1:0] {ST_SYNC, ST_RUN, ST_HALT} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, npc;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [PTR_W-1:0]   top_q, top_d;
   logic               full_q, empty_q;
   logic               at_full, at_empty, push;
   logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

   function automatic logic signed [ADDR_W-1:0] sext_offset(input logic [OFFSET_W-1:0] o);
      return {{PAGE_W{o[OFFSET_W-1]}}, o};
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(STACK_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? PTR_W'(STACK_DEPTH - 1) : p - PTR_W'(1);
   endfunction

   assign at_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign at_empty = (depth_q == '0);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      top_d   = top_q;
      push    = 1'b0;
      npc     = pc_q + ADDR_W'(1);
      if (state_q == ST_SYNC) begin
         state_d = ST_RUN;
      end else if (bus.restart) begin
         state_d = ST_RUN;
         pc_d    = bus.start_address;
         depth_d = '0;
         top_d   = '0;
      end else if (state_q == ST_RUN) begin
         case (bus.op)
            OP_HOLD: pc_d = pc_q;
            OP_BR:   pc_d = bus.cond ? pc_q + $unsigned(sext_offset(bus.offset)) : npc;
            OP_JMP:  pc_d = bus.cond ? bus.target : npc;
            OP_PAGE: pc_d = {bus.page, bus.offset};
            OP_CALL: begin
`ifdef PCSEQ_STACK_GUARD_EN
               if (at_full) begin
                  state_d = ST_HALT;
               end else begin
                  push    = 1'b1;
                  pc_d    = bus.target;
                  top_d   = ptr_inc(top_q);
                  depth_d = depth_q + DEPTH_W'(1);
               end
`else
               // when full, the write lands on the oldest slot
               push  = 1'b1;
               pc_d  = bus.target;
               top_d = ptr_inc(top_q);
               if (!at_full) depth_d = depth_q + DEPTH_W'(1);
`endif
            end
            OP_RET: begin
               if (at_empty) begin
`ifdef PCSEQ_STACK_GUARD_EN
                  state_d = ST_HALT;
`else
                  pc_d = npc;
`endif
               end else begin
                  pc_d    = stack_mem[ptr_dec(top_q)];
                  top_d   = ptr_dec(top_q);
                  depth_d = depth_q - DEPTH_W'(1);
               end
            end
            default: pc_d = npc;
         endcase
      end
   end

   always_ff @(posedge clk or negedge start_n) begin
      if (!start_n) begin
         state_q <= ST_SYNC;
         pc_q    <= ADDR_W'(RESET_ADDR);
         depth_q <= '0;
         top_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         top_q   <= top_d;
         full_q  <= (depth_d == DEPTH_W'(STACK_DEPTH));
         empty_q <= (depth_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) stack_mem[top_q] <= npc;
   end

   assign bus.pc        = pc_q;
   assign bus.depth     = depth_q;
   assign bus.stk_full  = full_q;
   assign bus.stk_empty = empty_q;
`ifdef PCSEQ_STACK_GUARD_EN
   assign bus.err = (state_q == ST_HALT);
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random ops against a queue-based model.
module tb_pc_sequencer;
   localparam int AW  = 10;
   localparam int OW  = 8;
   localparam int D   = 4;
   localparam int MOD = 1 << AW;
`ifdef PCSEQ_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic start_n;

   pc_seq_if #(.ADDR_W(AW), .OFFSET_W(OW), .STACK_DEPTH(D)) bus ();

   pc_sequencer #(.ADDR_W(AW), .OFFSET_W(OW), .STACK_DEPTH(D), .RESET_ADDR(0)) dut (
      .clk     (clk),
      .start_n (start_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // reference model: pc as an integer, return stack as a queue (back = newest)
   int m_pc;
   int m_stk[$];
   bit m_err;
   bit m_live;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input int exp_pc, input int exp_depth);
      chk({name, " pc"}, 32'(bus.pc), exp_pc);
      chk({name, " model_pc"}, m_pc, exp_pc);
      chk({name, " depth"}, 32'(bus.depth), exp_depth);
   endtask

   task automatic model_reset();
      m_pc = 0;
      m_stk.delete();
      m_err = 1'b0;
      m_live = 1'b0;
   endtask

   task automatic model_update();
      int npc;
      int off;
      if (!start_n) return;
      if (!m_live) begin
         m_live = 1'b1;
         return;
      end
      if (bus.restart) begin
         m_pc = int'(bus.start_address);
         m_stk.delete();
         m_err = 1'b0;
         return;
      end
      if (m_err) return;
      npc = (m_pc + 1) % MOD;
      case (int'(bus.op))
         1: m_pc = m_pc;
         2: begin
            off = int'(bus.offset);
            if (off >= (1 << (OW - 1))) off -= (1 << OW);
            m_pc = bus.cond ? (m_pc + off + MOD) % MOD : npc;
         end
         3: m_pc = bus.cond ? int'(bus.target) : npc;
         4: m_pc = int'(bus.page) * (1 << OW) + int'(bus.offset);
         5: begin
            if (m_stk.size() == D && GUARD) m_err = 1'b1;
            else begin
               if (m_stk.size() == D) void'(m_stk.pop_front());
               m_stk.push_back(npc);
               m_pc = int'(bus.target);
            end
         end
         6: begin
            if (m_stk.size() == 0) begin
               if (GUARD) m_err = 1'b1;
               else m_pc = npc;
            end else m_pc = m_stk.pop_back();
         end
         default: m_pc = npc;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic do_op(input int op, input bit c, input int off, input int pg, input int tgt);
      bus.op     = 3'(op);
      bus.cond   = c;
      bus.offset = OW'(off);
      bus.page   = (AW - OW)'(pg);
      bus.target = AW'(tgt);
      tick();
   endtask

   task automatic do_restart(input int addr);
      bus.restart       = 1'b1;
      bus.start_address = AW'(addr);
      bus.op            = 3'd0;
      tick();
      bus.restart = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc", 32'(bus.pc), m_pc);
         chk("depth", 32'(bus.depth), m_stk.size());
         chk("stk_full", 32'(bus.stk_full), (m_stk.size() == D) ? 1 : 0);
         chk("stk_empty", 32'(bus.stk_empty), (m_stk.size() == 0) ? 1 : 0);
         chk("err", 32'(bus.err), m_err);
      end
   end

   initial begin
      int exp_ret[4];
      start_n           = 1'b0;
      bus.restart       = 1'b0;
      bus.start_address = '0;
      bus.op            = 3'd0;
      bus.cond          = 1'b0;
      bus.offset        = '0;
      bus.page          = '0;
      bus.target        = '0;
      model_reset();
      #1 chk_en = 1'b1;
      repeat (2) tick();
      lit("reset", 0, 0);
      chk("reset empty", 32'(bus.stk_empty), 1);

      start_n = 1'b1;
      tick();
      lit("sync_edge", 0, 0);
      for (int i = 1; i <= 3; i++) begin
         do_op(0, 0, 0, 0, 0);
         lit("next", i, 0);
      end

      do_restart('h3FF);
      lit("load_3ff", 'h3FF, 0);
      do_op(0, 0, 0, 0, 0);
      lit("wrap_next", 'h000, 0);

      do_restart('h010);
      do_op(2, 1, 'hFE, 0, 0);
      lit("br_back", 'h00E, 0);
      do_restart('h010);
      do_op(2, 0, 'hFE, 0, 0);
      lit("br_not_taken", 'h011, 0);
      do_restart('h001);
      do_op(2, 1, 'hFC, 0, 0);
      lit("br_wrap", 'h3FD, 0);

      do_op(4, 0, 'h34, 2, 0);
      lit("page", 'h234, 0);
      do_op(3, 1, 0, 0, 'h155);
      lit("jmp", 'h155, 0);
      do_op(3, 0, 0, 0, 'h2AA);
      lit("jmp_not_taken", 'h156, 0);

      do_restart('h020);
      do_op(5, 0, 0, 0, 'h100);
      lit("call1", 'h100, 1);
      do_op(5, 0, 0, 0, 'h200);
      lit("call2", 'h200, 2);
      do_op(6, 0, 0, 0, 0);
      lit("ret1", 'h101, 1);
      do_op(6, 0, 0, 0, 0);
      lit("ret2", 'h021, 0);
      chk("nested empty", 32'(bus.stk_empty), 1);

      do_restart('h000);
      for (int i = 0; i < 4; i++) do_op(5, 0, 0, 0, 'h100 + 16 * i);
      lit("call4", 'h130, 4);
      chk("full after 4", 32'(bus.stk_full), 1);
      do_op(5, 0, 0, 0, 'h140);
`ifdef PCSEQ_STACK_GUARD_EN
      lit("ovf_freeze", 'h130, 4);
      chk("ovf err", 32'(bus.err), 1);
      do_op(0, 0, 0, 0, 0);
      lit("halt_next", 'h130, 4);
      do_op(6, 0, 0, 0, 0);
      lit("halt_ret", 'h130, 4);
      do_restart('h040);
      lit("ovf_restart", 'h040, 0);
      chk("restart clears err", 32'(bus.err), 0);
      do_op(6, 0, 0, 0, 0);
      lit("udf_freeze", 'h040, 0);
      chk("udf err", 32'(bus.err), 1);
      do_restart('h040);
`else
      lit("ovf_call5", 'h140, 4);
      exp_ret = '{'h131, 'h121, 'h111, 'h101};
      for (int i = 0; i < 4; i++) begin
         do_op(6, 0, 0, 0, 0);
         lit("ovf_ret", exp_ret[i], 3 - i);
      end
      do_op(6, 0, 0, 0, 0);
      lit("udf_ret", 'h102, 0);
      chk("err tied", 32'(bus.err), 0);
`endif

      do_restart('h050);
      do_op(5, 0, 0, 0, 'h300);
      lit("prio_pre", 'h300, 1);
      bus.restart       = 1'b1;
      bus.start_address = AW'('h077);
      bus.op            = 3'd5;
      bus.target        = AW'('h3AA);
      tick();
      bus.restart = 1'b0;
      lit("prio_restart", 'h077, 0);

      do_op(5, 0, 0, 0, 'h180);
      do_op(5, 0, 0, 0, 'h1C0);
      lit("async_pre", 'h1C0, 2);
      #2;
      start_n = 1'b0;
      model_reset();
      #1;
      lit("async_reset", 0, 0);
      chk("async empty", 32'(bus.stk_empty), 1);
      tick();
      start_n = 1'b1;
      tick();
      do_op(0, 0, 0, 0, 0);
      lit("after_async", 1, 0);

      for (int i = 0; i < 3000; i++) begin
         bus.restart       = ($urandom_range(0, 99) < 3);
         bus.start_address = AW'($urandom);
         bus.op            = 3'($urandom);
         bus.cond          = 1'($urandom);
         bus.offset        = OW'($urandom);
         bus.page          = (AW - OW)'($urandom);
         bus.target        = AW'($urandom);
         tick();
      end
      bus.restart = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
